// File: rtl/trng_word_engine.sv
// rtl/trng_word_engine.sv - multi-source TRNG sampler, debiaser, health test and word packer
//
// Ports:
//   clk, rst      : clock; synchronous active-high reset
//   enable        : run enable; low freezes divider, debias state and word assembly
//   entropy_in    : asynchronous ring-oscillator outputs (NUM_SRC bits)
//   sample_div    : sample period minus 1 in clk cycles (0 = every cycle)
//   vn_en         : 1 = von Neumann debias, 0 = raw samples
//   health_clr    : pulse clearing health_fail and the repetition counter
//   word_data     : completed random word (WORD_W bits)
//   word_valid    : word_data holds a complete word
//   word_ready    : consumer accepts the word when word_valid and word_ready are high
//   health_fail   : sticky repetition-count failure
//   drop_cnt      : saturating count of whole words lost while the output was full
module trng_word_engine #(
    parameter int NUM_SRC   = 8,
    parameter int WORD_W    = 32,
    parameter int DIV_W     = 8,
    parameter int RCT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] entropy_in,
    input  logic [DIV_W-1:0]   sample_div,
    input  logic               vn_en,
    input  logic               health_clr,
    output logic [WORD_W-1:0]  word_data,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               health_fail,
    output logic [15:0]        drop_cnt
);

    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [7:0]       RCT_MAX  = 8'(RCT_LIMIT);

    typedef enum logic {VN_IDLE, VN_HAVE1} vn_state_t;

    logic [NUM_SRC-1:0] sync_a, sync_b;
    logic               comb_bit;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               samp, samp_v;
    logic [7:0]         rct_cnt, rct_next;
    logic               prev_samp;
    vn_state_t          vn_state, vn_next;
    logic               vn_first;
    logic               step;
    logic               emit, acc_bit;
    logic               accept, done, handshake;
    logic [WORD_W-1:0]  shreg, word_next;
    logic [CNT_W-1:0]   bit_cnt;

    // Two-flop synchroniser per source, then XOR-combine
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= entropy_in;
            sync_b <= sync_a;
        end
    end

    assign comb_bit = ^sync_b;

    // >= rather than == so a sample_div lowered below the running count
    // still fires on the very next compare instead of waiting for wrap-around.
    assign tick = enable && (div_cnt >= sample_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            samp    <= 1'b0;
            samp_v  <= 1'b0;
        end else begin
            if (enable) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end
            if (tick) begin
                samp <= comb_bit;
            end
            samp_v <= tick;
        end
    end

    // Repetition count: a zero count means no reference sample yet
    always_comb begin
        rct_next = 8'd1;
        if (rct_cnt != 8'd0 && samp == prev_samp) begin
            rct_next = (rct_cnt == RCT_MAX) ? rct_cnt : rct_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rct_cnt     <= 8'd0;
            prev_samp   <= 1'b0;
            health_fail <= 1'b0;
        end else if (health_clr) begin
            rct_cnt     <= 8'd0;
            health_fail <= 1'b0;
        end else if (samp_v) begin
            rct_cnt   <= rct_next;
            prev_samp <= samp;
            if (rct_next == RCT_MAX) begin
                health_fail <= 1'b1;
            end
        end
    end

    // Von Neumann corrector
    assign step = enable && samp_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            vn_state <= VN_IDLE;
            vn_first <= 1'b0;
        end else begin
            vn_state <= vn_next;
            if (vn_en && step && vn_state == VN_IDLE) begin
                vn_first <= samp;
            end
        end
    end

    always_comb begin
        vn_next = vn_state;
        if (!vn_en) begin
            vn_next = VN_IDLE;
        end else if (step) begin
            vn_next = (vn_state == VN_IDLE) ? VN_HAVE1 : VN_IDLE;
        end
    end

    always_comb begin
        emit    = 1'b0;
        acc_bit = 1'b0;
        if (step) begin
            if (!vn_en) begin
                emit    = 1'b1;
                acc_bit = samp;
            end else if (vn_state == VN_HAVE1 && vn_first != samp) begin
                emit    = 1'b1;
                acc_bit = vn_first;
            end
        end
    end

    // Word assembly, LSB-first
    assign accept    = emit && !health_fail;
    assign done      = accept && (bit_cnt == LAST_BIT);
    assign handshake = word_valid && word_ready;

    always_comb begin
        word_next          = shreg;
        word_next[bit_cnt] = acc_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            drop_cnt   <= 16'd0;
        end else begin
            if (accept) begin
                shreg   <= word_next;
                bit_cnt <= done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (done) begin
                // Output register free or being emptied this cycle: load; else drop
                if (!word_valid || word_ready) begin
                    word_data  <= word_next;
                    word_valid <= 1'b1;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (handshake) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trng_word_engine.sv
// tb/tb_trng_word_engine.sv - self-checking bench for trng_word_engine
module tb_trng_word_engine;

    localparam int W     = 8;
    localparam int LIMIT = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [7:0]   entropy_in = 8'h00;
    logic [7:0]   sample_div = 8'h00;
    logic         vn_en = 1'b0;
    logic         health_clr = 1'b0;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         word_ready = 1'b1;
    logic         health_fail;
    logic [15:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    trng_word_engine #(
        .NUM_SRC(8), .WORD_W(W), .DIV_W(8), .RCT_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .entropy_in(entropy_in),
        .sample_div(sample_div), .vn_en(vn_en), .health_clr(health_clr),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .health_fail(health_fail), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bit stream -> samples -> accepted bits -> words
    bit         mdl_on = 0;
    bit         mq_old, mq_new;
    int         m_cnt;
    bit         m_sv, m_samp;
    int         m_run;
    bit         m_prev, m_fail;
    bit         m_pend, m_first;
    bit         m_acc[$];
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_drop;

    task automatic model_step();
        bit hs, emit, b, done, comb, tick;
        logic [W-1:0] w;
        if (rst) begin
            mq_old = 0; mq_new = 0; m_cnt = 0; m_sv = 0; m_samp = 0;
            m_run = 0; m_prev = 0; m_fail = 0; m_pend = 0; m_first = 0;
            m_acc.delete(); m_valid = 0; m_data = '0; m_drop = 0;
            return;
        end
        hs = m_valid && word_ready;
        emit = 0; b = 0; done = 0; w = '0;
        if (enable && m_sv) begin
            if (!vn_en) begin
                emit = 1; b = m_samp;
            end else if (!m_pend) begin
                m_pend = 1; m_first = m_samp;
            end else begin
                m_pend = 0;
                if (m_first != m_samp) begin emit = 1; b = m_first; end
            end
        end
        if (!vn_en) m_pend = 0;
        if (emit && !m_fail) begin
            m_acc.push_back(b);
            if (m_acc.size() == W) begin
                for (int k = 0; k < W; k++) w[k] = m_acc[k];
                m_acc.delete();
                done = 1;
            end
        end
        if (m_sv) begin
            if (m_run > 0 && m_samp == m_prev) m_run = (m_run < LIMIT) ? m_run + 1 : m_run;
            else m_run = 1;
            m_prev = m_samp;
            if (m_run == LIMIT) m_fail = 1;
        end
        if (health_clr) begin m_run = 0; m_fail = 0; end
        if (done) begin
            if (!m_valid || hs) begin m_data = w; m_valid = 1; end
            else if (m_drop < 65535) m_drop++;
        end else if (hs) begin
            m_valid = 0;
        end
        comb = mq_old; mq_old = mq_new; mq_new = ^entropy_in;
        tick = 0;
        if (enable) begin
            if (m_cnt >= int'(sample_div)) begin tick = 1; m_cnt = 0; end
            else m_cnt++;
        end
        m_sv = tick;
        if (tick) m_samp = comb;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        mdl_on = 1;
    end

    initial forever begin
        @(negedge clk);
        if (mdl_on) begin
            check("cmp_valid", word_valid, m_valid);
            if (m_valid) check("cmp_data", word_data, m_data);
            check("cmp_fail", health_fail, m_fail);
            check("cmp_drop", drop_cnt, m_drop);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; entropy_in = 8'h00; health_clr = 0;
        word_ready = 1; vn_en = 0; sample_div = 8'd0;
        step(2);
    endtask

    // Value to present before edge k so that the sample taken at edge k+2 alternates
    function automatic logic [7:0] alt_val(input int k, input logic [7:0] hi, input logic [7:0] lo);
        return (k % 2 == 1) ? hi : lo;
    endfunction

    logic [21:0] vn_pat;

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_fail", health_fail, 0);
        check("rst_drop", drop_cnt, 0);

        // Alternating raw samples; first word includes the two post-reset zeros
        rst = 0; enable = 1; entropy_in = 8'h01;
        for (int k = 1; k <= 17; k++) begin
            step(1);
            if (k == 8)  check("t1_valid_e8", word_valid, 0);
            if (k == 9)  begin check("t1_valid_e9", word_valid, 1); check("t1_word1", word_data, 8'h54); end
            if (k == 10) check("t1_valid_e10", word_valid, 0);
            if (k == 17) begin check("t1_valid_e17", word_valid, 1); check("t1_word2", word_data, 8'h55); end
            entropy_in = alt_val(k + 1, 8'h01, 8'h00);
        end
        enable = 0;
        for (int k = 0; k < 5; k++) begin entropy_in = 8'($urandom); step(1); end
        enable = 1;
        for (int k = 0; k < 12; k++) begin entropy_in = 8'($urandom); step(1); end

        // Von Neumann pairs 00,10,01,11,00,10,10,10,01,01,10 -> 1,0,1,1,1,0,0,1
        vn_pat = 22'b0110100101_0100111001_00;
        do_reset();
        vn_en = 1; rst = 0; enable = 1; entropy_in = {7'b0, vn_pat[2]};
        for (int j = 1; j <= 23; j++) begin
            step(1);
            if (j == 22) check("t2_valid_e22", word_valid, 0);
            if (j == 23) begin check("t2_valid_e23", word_valid, 1); check("t2_word", word_data, 8'h9D); end
            entropy_in = (j <= 19) ? {7'b0, vn_pat[j+2]} : 8'h00;
        end
        for (int j = 0; j < 24; j++) begin
            if (j % 3 == 0) vn_en = ~vn_en;
            entropy_in = 8'($urandom);
            step(1);
        end

        // Repetition count on constant input, clear and re-trip
        do_reset();
        rst = 0; enable = 1; entropy_in = 8'h00;
        for (int k = 1; k <= 47; k++) begin
            step(1);
            if (k == 9)  begin check("t3_valid_e9", word_valid, 1); check("t3_word", word_data, 8'h00); end
            if (k == 16) check("t3_fail_e16", health_fail, 0);
            if (k == 17) begin check("t3_fail_e17", health_fail, 1); check("t3_valid_e17", word_valid, 1); end
            if (k == 30) begin check("t3_blocked", word_valid, 0); check("t3_sticky", health_fail, 1); end
            if (k == 31) check("t3_cleared", health_fail, 0);
            if (k == 39) check("t3_valid_e39", word_valid, 1);
            if (k == 46) check("t3_fail_e46", health_fail, 0);
            if (k == 47) check("t3_retrip", health_fail, 1);
            health_clr = (k == 30);
        end

        // Divider period 4, then lowered to 0 mid-count
        do_reset();
        sample_div = 8'd3; rst = 0; enable = 1; entropy_in = 8'h01;
        for (int k = 1; k <= 42; k++) begin
            step(1);
            if (k == 32) check("t4_valid_e32", word_valid, 0);
            if (k == 33) begin
                check("t4_valid_e33", word_valid, 1);
                check("t4_word1", word_data, 8'hFF);
                sample_div = 8'd0; entropy_in = 8'h00;
            end
            if (k == 41) check("t4_valid_e41", word_valid, 0);
            if (k == 42) begin check("t4_valid_e42", word_valid, 1); check("t4_word2", word_data, 8'h03); end
        end

        // Backpressure: hold, drop two, then completion coinciding with handshake
        do_reset();
        word_ready = 0; rst = 0; enable = 1; entropy_in = 8'h07;
        for (int k = 1; k <= 36; k++) begin
            step(1);
            if (k == 9)  begin check("t5_word1", word_data, 8'h54); check("t5_drop0", drop_cnt, 0); end
            if (k == 17) check("t5_drop1", drop_cnt, 1);
            if (k == 32) begin
                check("t5_held", word_data, 8'h54);
                check("t5_held_v", word_valid, 1);
                check("t5_drop2", drop_cnt, 2);
                word_ready = 1;
            end
            if (k == 33) begin
                check("t5_swap_v", word_valid, 1);
                check("t5_swap_d", word_data, 8'h55);
                check("t5_swap_drop", drop_cnt, 2);
            end
            entropy_in = alt_val(k + 1, 8'h07, 8'h03);
        end

        // Reset mid-word, then a clean first word
        rst = 1;
        step(1);
        check("t6_valid", word_valid, 0);
        check("t6_data", word_data, 0);
        check("t6_drop", drop_cnt, 0);
        check("t6_fail", health_fail, 0);
        rst = 0; entropy_in = 8'h01;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            if (k == 8) check("t6_valid_e8", word_valid, 0);
            if (k == 9) begin check("t6_valid_e9", word_valid, 1); check("t6_word", word_data, 8'h54); end
            entropy_in = alt_val(k + 1, 8'h01, 8'h00);
        end

        // Mixed traffic against the model
        for (int k = 0; k < 300; k++) begin
            entropy_in = 8'($urandom);
            word_ready = 1'($urandom);
            if (k % 40 == 0) sample_div = 8'($urandom_range(0, 2));
            if (k % 70 == 35) vn_en = ~vn_en;
            enable = ($urandom_range(0, 9) != 0);
            health_clr = (k % 97 == 50);
            step(1);
        end
        health_clr = 0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
